// File: rtl/dbus_arb_pkg.sv
// Shared constants for the two-master data-bus arbiter: master IDs and
// access-size encodings.
package dbus_arb_pkg;

    localparam logic MID_CPU = 1'b0;
    localparam logic MID_AUX = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/dbus_arb_id_fifo.sv
// Ordered record of which master issued each outstanding read; one bit per
// entry, supports push and pop in the same cycle.
module dbus_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             push_id_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= push_id_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares one simple-bus data port between the CPU (m0) and an auxiliary
// requester (m1). Define DBUS_ARB_ROUND_ROBIN_EN for round-robin contention.
module dbus_arbiter
    import dbus_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             m0_cmd_valid,
    output logic             m0_cmd_ready,
    input  logic             m0_cmd_payload_wr,
    input  logic [31:0]      m0_cmd_payload_address,
    input  logic [31:0]      m0_cmd_payload_data,
    input  logic [1:0]       m0_cmd_payload_size,
    output logic             m0_rsp_ready,
    output logic             m0_rsp_error,
    output logic [31:0]      m0_rsp_data,

    input  logic             m1_cmd_valid,
    output logic             m1_cmd_ready,
    input  logic             m1_cmd_payload_wr,
    input  logic [31:0]      m1_cmd_payload_address,
    input  logic [31:0]      m1_cmd_payload_data,
    input  logic [1:0]       m1_cmd_payload_size,
    output logic             m1_rsp_ready,
    output logic             m1_rsp_error,
    output logic [31:0]      m1_rsp_data,

    output logic             s_cmd_valid,
    input  logic             s_cmd_ready,
    output logic             s_cmd_payload_wr,
    output logic [31:0]      s_cmd_payload_address,
    output logic [31:0]      s_cmd_payload_data,
    output logic [1:0]       s_cmd_payload_size,
    input  logic             s_rsp_ready,
    input  logic             s_rsp_error,
    input  logic [31:0]      s_rsp_data,

    output logic [CNT_W-1:0] outstanding,
    output logic             err_unexpected_rsp
);

    logic grant;
    logic gnt_valid;
    logic read_blocked;
    logic accept;
    logic push, pop;
    logic fifo_full, fifo_empty, fifo_head;
    logic lock_q, lock_d;
    logic lock_id_q, lock_id_d;
    logic err_q, err_d;
    logic locked_valid;

`ifdef DBUS_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
`endif

    assign locked_valid = (lock_id_q == MID_CPU) ? m0_cmd_valid : m1_cmd_valid;

    always_comb begin
        grant = MID_CPU;
        if (lock_q && locked_valid) begin
            grant = lock_id_q;
        end else if (m0_cmd_valid && m1_cmd_valid) begin
`ifdef DBUS_ARB_ROUND_ROBIN_EN
            grant = ~last_q;
`else
            grant = MID_CPU;
`endif
        end else if (m1_cmd_valid) begin
            grant = MID_AUX;
        end
    end

    always_comb begin
        if (grant == MID_CPU) begin
            gnt_valid             = m0_cmd_valid;
            s_cmd_payload_wr      = m0_cmd_payload_wr;
            s_cmd_payload_address = m0_cmd_payload_address;
            s_cmd_payload_data    = m0_cmd_payload_data;
            s_cmd_payload_size    = m0_cmd_payload_size;
        end else begin
            gnt_valid             = m1_cmd_valid;
            s_cmd_payload_wr      = m1_cmd_payload_wr;
            s_cmd_payload_address = m1_cmd_payload_address;
            s_cmd_payload_data    = m1_cmd_payload_data;
            s_cmd_payload_size    = m1_cmd_payload_size;
        end
    end

    // Full check deliberately ignores a same-cycle pop to keep this path short.
    assign read_blocked = gnt_valid & ~s_cmd_payload_wr & fifo_full;
    assign s_cmd_valid  = ~reset & gnt_valid & ~read_blocked;
    assign accept       = s_cmd_valid & s_cmd_ready;
    assign m0_cmd_ready = accept & (grant == MID_CPU);
    assign m1_cmd_ready = accept & (grant == MID_AUX);

    assign push = accept & ~s_cmd_payload_wr;
    assign pop  = s_rsp_ready & ~fifo_empty;

    assign m0_rsp_ready = pop & (fifo_head == MID_CPU);
    assign m1_rsp_ready = pop & (fifo_head == MID_AUX);
    assign m0_rsp_data  = s_rsp_data;
    assign m1_rsp_data  = s_rsp_data;
    assign m0_rsp_error = s_rsp_error;
    assign m1_rsp_error = s_rsp_error;

    // Hold the grant on a stalled master so its payload stays stable.
    assign lock_d    = gnt_valid & ~accept;
    assign lock_id_d = grant;
    assign err_d     = err_q | (s_rsp_ready & fifo_empty);

    assign err_unexpected_rsp = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q    <= 1'b0;
            lock_id_q <= MID_CPU;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
        end
    end

`ifdef DBUS_ARB_ROUND_ROBIN_EN
    assign last_d = accept ? grant : last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= MID_AUX;
        else       last_q <= last_d;
    end
`endif

    dbus_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (reset),
        .push_i    (push),
        .push_id_i (grant),
        .pop_i     (pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head),
        .count_o   (outstanding)
    );

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-master arbiter that shares the single VexRiscv simple-bus data port (memory and peripheral decode) between the CPU dBus (m0) and a second requester (m1), e.g. a UART program loader or DMA.
- Forwards one command per cycle downstream with zero added command latency.
- Records which master issued each outstanding read in an ID FIFO and routes in-order read responses back to that master.

Parameters:
- MAX_OUTSTANDING, 4, maximum accepted reads awaiting a response (power of 2, >=2).
- CNT_W, 3, width of outstanding counter, equal to clog2(MAX_OUTSTANDING)+1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mN_cmd_valid  in  1  command valid, N=0,1
- mN_cmd_ready  out  1  command accepted this cycle
- mN_cmd_payload_wr  in  1  1=write, 0=read
- mN_cmd_payload_address  in  32  byte address
- mN_cmd_payload_data  in  32  write data
- mN_cmd_payload_size  in  2  0=byte, 1=half, 2=word
- mN_rsp_ready  out  1  read response valid pulse
- mN_rsp_error  out  1  response error, qualified by mN_rsp_ready
- mN_rsp_data  out  32  read data, qualified by mN_rsp_ready
- s_cmd_valid  out  1  downstream command valid
- s_cmd_ready  in  1  downstream accepts
- s_cmd_payload_wr/address/data/size  out  1/32/32/2  muxed payload
- s_rsp_ready  in  1  downstream read response valid
- s_rsp_error  in  1  downstream response error
- s_rsp_data  in  32  downstream read data
- outstanding  out  CNT_W  reads in flight
- err_unexpected_rsp  out  1  sticky flag: response arrived with no read in flight

Behaviour:
- Reset: all cmd_ready=0, all rsp_ready=0, s_cmd_valid=0, outstanding=0, err_unexpected_rsp=0. ID FIFO is emptied, lock is cleared, last-grant=m1 (so m0 wins first).
- Grant is combinational from the valids, the lock register and the policy. The s_cmd_* payload is muxed from the granted master.
- s_cmd_valid = granted valid AND NOT read_blocked.
- mN_cmd_ready = (grant==N) AND s_cmd_ready AND s_cmd_valid.
- Lock: if the granted master is valid and not accepted, its grant holds in following cycles until acceptance, so the payload stays stable. The lock clears on acceptance or when that master drops valid.
- read_blocked: the granted command is a read and the FIFO is full. The full check ignores a same-cycle pop, which is conservative. Writes are never blocked.
- Accepted read: push the master ID; outstanding increments.
- s_rsp_ready: pop the FIFO head; outstanding decrements.
- Simultaneous push and pop: outstanding is unchanged and the FIFO stays ordered.
- Response routing is combinational in the same cycle: mX_rsp_ready = s_rsp_ready AND head==X. The other master's rsp_ready stays 0.
- rsp_data and rsp_error are broadcast to both masters and are valid only with rsp_ready.
- s_rsp_ready with the FIFO empty: the response is dropped, no master pulses, err_unexpected_rsp sets and holds until reset.
- Downstream must respond to reads in order. Write commands produce no response.
- Reset mid-transaction: in-flight IDs are discarded. Late responses after reset are flagged as unexpected.

Optional Feature:
- DBUS_ARB_ROUND_ROBIN_EN defined: on contention (both valid, no lock), the master not granted last wins. last-grant updates on each accepted command.
- Undefined: fixed priority, m0 (CPU) always wins contention and the last-grant register is absent. m1 can starve while m0 issues back-to-back commands.

Decomposition:
- Package dbus_arb_pkg holds:
  - master ID constants MID_CPU=1'b0 and MID_AUX=1'b1
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2
- Sub-module dbus_arb_id_fifo: 1-bit wide, MAX_OUTSTANDING deep, with push/pop/full/empty/count and simultaneous push+pop support.

Test Plan:
- Only m0 reads 0x100, s_cmd_ready=1, response next cycle with data 0xDEADBEEF -> m0_cmd_ready=1 same cycle, m0_rsp_ready=1 with 0xDEADBEEF, m1_rsp_ready=0, outstanding 1 then 0.
- Both read in the same cycle, fixed priority -> m0 accepted cycle 0, m1 cycle 1; responses A then B route to m0 then m1. With DBUS_ARB_ROUND_ROBIN_EN, a second contention goes to m1 first.
- m1 valid with s_cmd_ready=0 for 3 cycles while m0 asserts valid at cycle 1 -> grant stays on m1, payload stable, m1 accepted at cycle 3, then m0.
- Issue 4 reads with responses withheld -> outstanding=4, a 5th read sees cmd_ready=0 while a write to 0x80000000 is still accepted. After one response, the read is accepted the following cycle.
- s_rsp_ready pulse with no reads in flight -> no mN_rsp_ready, err_unexpected_rsp=1 and held. reset clears it to 0.
- Assert reset with 2 reads in flight -> outstanding=0 and ready outputs 0 immediately (async). A subsequent stray response sets err_unexpected_rsp.
